riscv_dmem_arbiter: RTL and testbench

//  Shares the single data-memory port of the RISC-V core between two requesters:
//  - Port C: the core load/store unit.
//  - Port D: the debug/loader port, used for testbench inspection and memory preload.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/riscv_arb_starve_ctr.sv | 42 ++++
 rtl/riscv_dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter: data width, arbiter state, response owner
// and the request bundle that is muxed onto the memory port.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        CORE_PRI,
        DBG_FORCE
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C,
        OWN_D
    } owner_e;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/riscv_arb_starve_ctr.sv
// Saturating count of consecutive core-won conflicts; raises force_o in the cycle
// the count reaches STARVE_MAX so the arbiter can switch state on that edge.
module riscv_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX_C) ? v : v + CW'(1);
    endfunction

    always_comb begin
        cnt_nxt = cnt_q;
        if (clr_i) begin
            cnt_nxt = '0;
        end else if (inc_i) begin
            cnt_nxt = sat_inc(cnt_q);
        end
    end

    assign force_o = (cnt_nxt == MAX_C);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of the single-cycle data memory.
// Optional statistics counters are enabled with the RISCV_DMEM_ARB_STATS_EN macro.
module riscv_dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int STARVE_MAX = 4,
    localparam int AW = $clog2(DMEM_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            c_valid_i,
    output logic            c_ready_o,
    input  logic            c_we_i,
    input  logic [3:0]      c_be_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wdata_i,
    output logic            c_rvalid_o,
    output logic [XLEN-1:0] c_rdata_o,
    input  logic            d_valid_i,
    output logic            d_ready_o,
    input  logic            d_we_i,
    input  logic [3:0]      d_be_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
`ifdef RISCV_DMEM_ARB_STATS_EN
    ,
    output logic [31:0]     stat_conflict_o,
    output logic [31:0]     stat_force_o
`endif
);

    arb_state_e state_q;
    arb_state_e state_nxt;
    owner_e     owner_p1;
    logic       gnt_c;
    logic       gnt_d;
    logic       conflict;
    logic       force_req;
    mem_req_t   c_req;
    mem_req_t   d_req;
    mem_req_t   sel;
    logic       unused_addr_bits;

    // Grants are held low while reset is asserted so every output reads zero.
    assign conflict = ~rst_i & (state_q == CORE_PRI) & c_valid_i & d_valid_i;

    riscv_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (conflict),
        .clr_i   (gnt_d),
        .force_o (force_req)
    );

    always_comb begin
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        state_nxt = state_q;
        if (!rst_i) begin
            unique case (state_q)
                CORE_PRI: begin
                    gnt_c = c_valid_i;
                    gnt_d = d_valid_i & ~c_valid_i;
                    if (force_req) state_nxt = DBG_FORCE;
                end
                DBG_FORCE: begin
                    gnt_d = d_valid_i;
                    gnt_c = c_valid_i & ~d_valid_i;
                    if (gnt_d) state_nxt = CORE_PRI;
                end
                default: state_nxt = CORE_PRI;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CORE_PRI;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign c_req = '{we: c_we_i, be: c_be_i, addr: c_addr_i, wdata: c_wdata_i};
    assign d_req = '{we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};

    always_comb begin
        sel = '0;
        if (gnt_c) begin
            sel = c_req;
        end else if (gnt_d) begin
            sel = d_req;
        end
    end

    assign c_ready_o   = gnt_c;
    assign d_ready_o   = gnt_d;
    assign mem_en_o    = gnt_c | gnt_d;
    assign mem_we_o    = sel.we;
    assign mem_be_o    = sel.be;
    assign mem_addr_o  = sel.addr[AW+1:2];
    assign mem_wdata_o = sel.wdata;
    assign unused_addr_bits = ^{sel.addr[XLEN-1:AW+2], sel.addr[1:0]};

    // ---- stage p1: response owner, data returns from memory this cycle ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_p1 <= OWN_NONE;
        end else if (gnt_c && !c_we_i) begin
            owner_p1 <= OWN_C;
        end else if (gnt_d && !d_we_i) begin
            owner_p1 <= OWN_D;
        end else begin
            owner_p1 <= OWN_NONE;
        end
    end

    assign c_rvalid_o = (owner_p1 == OWN_C);
    assign d_rvalid_o = (owner_p1 == OWN_D);
    assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

`ifdef RISCV_DMEM_ARB_STATS_EN
    logic [31:0] stat_conflict_q;
    logic [31:0] stat_force_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_conflict_q <= '0;
            stat_force_q    <= '0;
        end else begin
            if (conflict) stat_conflict_q <= sat_inc32(stat_conflict_q);
            if ((state_q == DBG_FORCE) && gnt_d) stat_force_q <= sat_inc32(stat_force_q);
        end
    end

    assign stat_conflict_o = stat_conflict_q;
    assign stat_force_o    = stat_force_q;
`endif

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Randomized and directed bench for riscv_dmem_arbiter, checked against a rule-level
// reference model (conflicts owed to debug, pending read responses).
module tb_riscv_dmem_arbiter;

    localparam int SM = 4;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid_i, c_we_i, d_valid_i, d_we_i;
    logic [3:0]  c_be_i, d_be_i;
    logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic        c_ready_o, d_ready_o, c_rvalid_o, d_rvalid_o;
    logic [31:0] c_rdata_o, d_rdata_o, mem_wdata_o;
    logic        mem_en_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [AW-1:0] mem_addr_o;
`ifdef RISCV_DMEM_ARB_STATS_EN
    logic [31:0] stat_conflict_o, stat_force_o;
`endif

    int total = 0;
    int bad = 0;

    // reference model state
    int starve;
    bit pend_c, pend_d;
    int n_conf, n_force;
    logic e_owed, e_cr, e_dr, e_en, e_we, e_crv, e_drv;
    logic [3:0] e_be;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wd, e_crd, e_drd;

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(
        .DMEM_WORDS (1024),
        .STARVE_MAX (SM)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .c_valid_i   (c_valid_i),
        .c_ready_o   (c_ready_o),
        .c_we_i      (c_we_i),
        .c_be_i      (c_be_i),
        .c_addr_i    (c_addr_i),
        .c_wdata_i   (c_wdata_i),
        .c_rvalid_o  (c_rvalid_o),
        .c_rdata_o   (c_rdata_o),
        .d_valid_i   (d_valid_i),
        .d_ready_o   (d_ready_o),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
`ifdef RISCV_DMEM_ARB_STATS_EN
        ,
        .stat_conflict_o (stat_conflict_o),
        .stat_force_o    (stat_force_o)
`endif
    );

    // Model update: debug is owed a grant once SM conflicts have gone unanswered.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            starve = 0; pend_c = 0; pend_d = 0; n_conf = 0; n_force = 0;
            e_cr = 0; e_dr = 0;
        end else begin
            if (e_dr) begin
                if (e_owed) n_force++;
                starve = 0;
            end else if (e_cr && d_valid_i) begin
                starve++;
                n_conf++;
            end
            pend_c = e_cr && !c_we_i;
            pend_d = e_dr && !d_we_i;
            e_cr = 0; e_dr = 0;
        end
    end

    function automatic logic [115:0] obs_v();
        return {c_ready_o, d_ready_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                c_rvalid_o, c_rdata_o, d_rvalid_o, d_rdata_o};
    endfunction

    function automatic logic [115:0] exp_v();
        return {e_cr, e_dr, e_en, e_we, e_be, e_addr, e_wd, e_crv, e_crd, e_drv, e_drd};
    endfunction

    task automatic drive(input logic cv, input logic cwe, input logic [3:0] cbe,
                         input logic [31:0] ca, input logic [31:0] cw,
                         input logic dv, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dw,
                         input logic [31:0] rd);
        @(negedge clk);
        c_valid_i = cv; c_we_i = cwe; c_be_i = cbe; c_addr_i = ca; c_wdata_i = cw;
        d_valid_i = dv; d_we_i = dwe; d_be_i = dbe; d_addr_i = da; d_wdata_i = dw;
        mem_rdata_i = rd;
        #1;
        e_owed = (starve >= SM);
        e_cr = cv && !(e_owed && dv);
        e_dr = dv && !e_cr;
        e_en = e_cr || e_dr;
        if (e_cr) begin
            e_we = cwe; e_be = cbe; e_addr = ca[AW+1:2]; e_wd = cw;
        end else if (e_dr) begin
            e_we = dwe; e_be = dbe; e_addr = da[AW+1:2]; e_wd = dw;
        end else begin
            e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
        end
        e_crv = pend_c; e_crd = pend_c ? rd : 32'd0;
        e_drv = pend_d; e_drd = pend_d ? rd : 32'd0;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, rd);
    endtask

    task automatic both_reads(input logic [31:0] rd);
        drive(1, 0, 4'hF, 32'h0000_0100, 32'h0, 1, 0, 4'hF, 32'h0000_0200, 32'h0, rd);
    endtask

    task automatic test_reset();
        rst = 1;
        c_valid_i = 1; c_we_i = 0; c_be_i = 4'hF; c_addr_i = 32'h40; c_wdata_i = 32'h1;
        d_valid_i = 1; d_we_i = 1; d_be_i = 4'hF; d_addr_i = 32'h80; d_wdata_i = 32'h2;
        mem_rdata_i = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (obs_v() !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", obs_v());
        end
`ifdef RISCV_DMEM_ARB_STATS_EN
        total++;
        if ({stat_conflict_o, stat_force_o} !== 64'd0) begin
            bad++;
            $display("FAIL reset_stats got=%h exp=0", {stat_conflict_o, stat_force_o});
        end
`endif
        @(negedge clk);
        c_valid_i = 0; d_valid_i = 0;
        rst = 0;
        idle(32'h1111_2222);
        total++;
        if (obs_v() !== exp_v()) begin
            bad++;
            $display("FAIL after_reset got=%h exp=%h", obs_v(), exp_v());
        end
    endtask

    task automatic test_core_read();
        drive(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, $urandom);
        total++;
        if (obs_v() !== exp_v() || mem_addr_o !== 10'd4 || c_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL core_read_req got=%h exp=%h addr=%0d", obs_v(), exp_v(), mem_addr_o);
        end
        idle(32'hDEAD_BEEF);
        total++;
        if (c_rvalid_o !== 1'b1 || c_rdata_o !== 32'hDEAD_BEEF || d_rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL core_read_resp got=%b/%h/%b exp=1/deadbeef/0", c_rvalid_o, c_rdata_o, d_rvalid_o);
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 6; i++) begin
            both_reads($urandom);
            total++;
            if (c_ready_o !== (i != 4) || d_ready_o !== (i == 4) || obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL starve_cyc%0d got c=%b d=%b obs=%h exp=%h", i, c_ready_o, d_ready_o, obs_v(), exp_v());
            end
        end
        idle($urandom);
        total++;
        if (obs_v() !== exp_v()) begin
            bad++;
            $display("FAIL starve_tail got=%h exp=%h", obs_v(), exp_v());
        end
    endtask

    task automatic test_dbg_write();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h20, 32'h1234_5678, $urandom);
        total++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd8 || mem_wdata_o !== 32'h1234_5678 ||
            mem_be_o !== 4'hF || d_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL dbg_write_req got we=%b addr=%0d wd=%h be=%h", mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        idle($urandom);
        total++;
        if (c_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL dbg_write_resp got c=%b d=%b exp=0/0", c_rvalid_o, d_rvalid_o);
        end
    endtask

    task automatic test_interleave();
        drive(1, 0, 4'hF, 32'h44, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, $urandom);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h88, 32'h0, 32'hC0DE_0001);
        total++;
        if (c_rvalid_o !== 1'b1 || c_rdata_o !== 32'hC0DE_0001 || d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL interleave_c got=%b/%h %b/%h", c_rvalid_o, c_rdata_o, d_rvalid_o, d_rdata_o);
        end
        idle(32'hC0DE_0002);
        total++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hC0DE_0002 || c_rvalid_o !== 1'b0 || c_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL interleave_d got=%b/%h %b/%h", d_rvalid_o, d_rdata_o, c_rvalid_o, c_rdata_o);
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < SM; i++) both_reads($urandom);
        drive(1, 0, 4'hF, 32'h30, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, $urandom);
        total++;
        if (c_ready_o !== 1'b1 || obs_v() !== exp_v()) begin
            bad++;
            $display("FAIL force_core_idle_dbg got=%h exp=%h", obs_v(), exp_v());
        end
        @(negedge clk);
        rst = 1; c_valid_i = 0; d_valid_i = 0; mem_rdata_i = 32'hFEED_FACE;
        #1;
        total++;
        if (c_rvalid_o !== 1'b0 || c_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_read got=%b/%h exp=0/0", c_rvalid_o, c_rdata_o);
        end
        @(negedge clk);
        rst = 0;
        both_reads($urandom);
        total++;
        if (c_ready_o !== 1'b1 || d_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_state got c=%b d=%b exp=1/0", c_ready_o, d_ready_o);
        end
        idle($urandom);
    endtask

`ifdef RISCV_DMEM_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1; c_valid_i = 0; d_valid_i = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 5; i++) both_reads($urandom);
        idle($urandom);
        total++;
        if (stat_conflict_o !== 32'd4 || stat_force_o !== 32'd1 ||
            stat_conflict_o !== n_conf || stat_force_o !== n_force) begin
            bad++;
            $display("FAIL stats got conf=%0d force=%0d exp=4/1", stat_conflict_o, stat_force_o);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom_range(0, 1), 4'($urandom), $urandom, $urandom,
                  ($urandom % 2) != 0, $urandom_range(0, 1), 4'($urandom), $urandom, $urandom,
                  $urandom);
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL random_cyc%0d got=%h exp=%h", i, obs_v(), exp_v());
            end
        end
`ifdef RISCV_DMEM_ARB_STATS_EN
        idle($urandom);
        total++;
        if (stat_conflict_o !== n_conf || stat_force_o !== n_force) begin
            bad++;
            $display("FAIL random_stats got=%0d/%0d exp=%0d/%0d", stat_conflict_o, stat_force_o, n_conf, n_force);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_starve();
        test_dbg_write();
        test_interleave();
        test_reset_mid_read();
`ifdef RISCV_DMEM_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
